// File: rtl/merger_pkg.sv
// Shared state encoding, word/lane helpers and default sizing for the merge tree.
package merger_pkg;

  localparam int unsigned KEY_W_DEFAULT      = 32;
  localparam int unsigned P_DEFAULT          = 16;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned MAX_KEY_W          = 64;
  localparam int unsigned MAX_DATA_W         = 4096;
  localparam int unsigned LOG2_2P            = $clog2(2 * P_DEFAULT);

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    MERGE   = 3'd1,
    DRAIN_A = 3'd2,
    DRAIN_B = 3'd3,
    FLUSH   = 3'd4,
    TERM    = 3'd5
  } state_e;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_KEY_W-1:0]  key_t;

  function automatic int unsigned log2_2p(int unsigned p);
    return $clog2(2 * p);
  endfunction

  // Callers zero-extend their word to word_t; key k sits at [k*key_w +: key_w].
  function automatic key_t lane(word_t word, int unsigned k, int unsigned key_w);
    word_t shifted;
    key_t  mask;
    shifted = word >> (k * key_w);
    mask    = (key_w >= MAX_KEY_W) ? '1 : ((key_t'(1) << key_w) - key_t'(1));
    return shifted[MAX_KEY_W-1:0] & mask;
  endfunction

  function automatic logic is_term(word_t word, int unsigned key_w);
    return lane(word, 0, key_w) == '0;
  endfunction

endpackage

// File: rtl/bitonic_merge_2p.sv
// Merges two ascending P-key lists: reverse the second to form a bitonic
// sequence, then sort it with log2(2P) half-cleaner levels.
module bitonic_merge_2p
  import merger_pkg::*;
#(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned P     = 16
) (
  input  logic [KEY_W*P-1:0] i_a,
  input  logic [KEY_W*P-1:0] i_b,
  output logic [KEY_W*P-1:0] o_low,
  output logic [KEY_W*P-1:0] o_high
);

  localparam int unsigned LEVELS = (P == P_DEFAULT) ? LOG2_2P : log2_2p(P);
  localparam int unsigned N      = 2 * P;

  logic [N*KEY_W-1:0] stage0;

  genvar gi, gl;

  for (gi = 0; gi < P; gi++) begin : g_load
    assign stage0[gi*KEY_W +: KEY_W]     = i_a[gi*KEY_W +: KEY_W];
    assign stage0[(P+gi)*KEY_W +: KEY_W] = i_b[(P-1-gi)*KEY_W +: KEY_W];
  end

  for (gl = 0; gl < LEVELS; gl++) begin : g_level
    localparam int unsigned S = P >> gl;
    logic [N*KEY_W-1:0] in_v;
    logic [N*KEY_W-1:0] out_v;

    if (gl == 0) begin : g_first
      assign in_v = stage0;
    end else begin : g_next
      assign in_v = g_level[gl-1].out_v;
    end

    // Each lane whose stride bit is clear owns the compare-exchange with lane+S.
    for (gi = 0; gi < N; gi++) begin : g_lane
      if ((gi & S) == 0) begin : g_cx
        logic [KEY_W-1:0] x;
        logic [KEY_W-1:0] y;
        assign x = in_v[gi*KEY_W +: KEY_W];
        assign y = in_v[(gi+S)*KEY_W +: KEY_W];
        assign out_v[gi*KEY_W +: KEY_W]     = (x <= y) ? x : y;
        assign out_v[(gi+S)*KEY_W +: KEY_W] = (x <= y) ? y : x;
      end
    end
  end

  assign o_low  = g_level[LEVELS-1].out_v[P*KEY_W-1:0];
  assign o_high = g_level[LEVELS-1].out_v[N*KEY_W-1:P*KEY_W];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible whenever not empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = mem[rd_ptr_q];
  assign do_wr   = i_wr_en && !o_full;
  assign do_rd   = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/merger_param.sv
// Two-input streaming merger: consumes two sorted runs of P-key words and emits
// one sorted run, each run closed by an all-zero terminator word.
module merger_param
  import merger_pkg::*;
#(
  parameter int unsigned KEY_W      = KEY_W_DEFAULT,
  parameter int unsigned P          = P_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned DATA_W     = KEY_W * P
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_run_done
);

  logic [DATA_W-1:0] head_a, head_b;
  logic              empty_a, empty_b;
  logic              full_a, full_b;
  logic              pop_a, pop_b;
  logic              a_term, b_term, a_first, both_avail, adv;
  logic [DATA_W-1:0] merge_w, merge_low, merge_high;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] h_q, h_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              term_q, term_d;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo_a (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_a_valid),
    .i_wr_data (i_a_data),
    .o_full    (full_a),
    .i_rd_en   (pop_a),
    .o_head    (head_a),
    .o_empty   (empty_a)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo_b (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_b_valid),
    .i_wr_data (i_b_data),
    .o_full    (full_b),
    .i_rd_en   (pop_b),
    .o_head    (head_b),
    .o_empty   (empty_b)
  );

  bitonic_merge_2p #(.KEY_W(KEY_W), .P(P)) u_merge (
    .i_a    (merge_w),
    .i_b    (h_q),
    .o_low  (merge_low),
    .o_high (merge_high)
  );

  assign o_a_ready  = !full_a;
  assign o_b_ready  = !full_b;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  // term_q marks that the word on o_data is the run terminator issued from TERM.
  assign o_run_done = valid_q && i_ready && term_q;

  assign adv        = !valid_q || i_ready;
  assign both_avail = !empty_a && !empty_b;
  assign a_term     = is_term(word_t'(head_a), KEY_W);
  assign b_term     = is_term(word_t'(head_b), KEY_W);
  assign a_first    = lane(word_t'(head_a), 0, KEY_W) <= lane(word_t'(head_b), 0, KEY_W);

  always_comb begin
    case (state_q)
      DRAIN_A: merge_w = head_a;
      DRAIN_B: merge_w = head_b;
      default: merge_w = a_first ? head_a : head_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    data_d  = data_q;
    valid_d = valid_q && !adv;
    term_d  = term_q && !adv;
    pop_a   = 1'b0;
    pop_b   = 1'b0;

    case (state_q)
      FILL: begin
        if (both_avail) begin
          if (a_term && b_term) begin
            state_d = TERM;
          end else if (a_term) begin
            h_d     = head_b;
            pop_b   = 1'b1;
            state_d = DRAIN_B;
          end else if (b_term) begin
            h_d     = head_a;
            pop_a   = 1'b1;
            state_d = DRAIN_A;
          end else begin
            h_d     = a_first ? head_a : head_b;
            pop_a   = a_first;
            pop_b   = !a_first;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        if (both_avail) begin
          if (a_term) begin
            state_d = DRAIN_B;
          end else if (b_term) begin
            state_d = DRAIN_A;
          end else if (adv) begin
            pop_a   = a_first;
            pop_b   = !a_first;
            data_d  = merge_low;
            h_d     = merge_high;
            valid_d = 1'b1;
            term_d  = 1'b0;
          end
        end
      end
      DRAIN_A: begin
        if (!empty_a) begin
          if (a_term) begin
            state_d = FLUSH;
          end else if (adv) begin
            pop_a   = 1'b1;
            data_d  = merge_low;
            h_d     = merge_high;
            valid_d = 1'b1;
            term_d  = 1'b0;
          end
        end
      end
      DRAIN_B: begin
        if (!empty_b) begin
          if (b_term) begin
            state_d = FLUSH;
          end else if (adv) begin
            pop_b   = 1'b1;
            data_d  = merge_low;
            h_d     = merge_high;
            valid_d = 1'b1;
            term_d  = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          data_d  = h_q;
          valid_d = 1'b1;
          term_d  = 1'b0;
          state_d = TERM;
        end
      end
      TERM: begin
        if (both_avail && a_term && b_term && adv) begin
          pop_a   = 1'b1;
          pop_b   = 1'b1;
          data_d  = '0;
          valid_d = 1'b1;
          term_d  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      h_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      term_q  <= term_d;
    end
  end

endmodule

// File: tb/tb_merger_param.sv
// Randomised bench for merger_param: a run-level model sorts all keys of a run
// and chunks them into words; DUT handshakes are compared against it.
module tb_merger_param;
  import merger_pkg::*;

  localparam int unsigned KW = 8;
  localparam int unsigned PP = 4;
  localparam int unsigned DW = KW * PP;
  localparam int unsigned FD = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [DW-1:0] i_a_data = '0;
  logic          i_a_valid = 1'b0;
  logic          o_a_ready;
  logic [DW-1:0] i_b_data = '0;
  logic          i_b_valid = 1'b0;
  logic          o_b_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_run_done;

  always #5 i_clk = ~i_clk;

  merger_param #(.KEY_W(KW), .P(PP), .FIFO_DEPTH(FD)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_a_data   (i_a_data),
    .i_a_valid  (i_a_valid),
    .o_a_ready  (o_a_ready),
    .i_b_data   (i_b_data),
    .i_b_valid  (i_b_valid),
    .o_b_ready  (o_b_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_run_done (o_run_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int unsigned keys[$], input int base);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < PP; k++) w[k*KW +: KW] = KW'(keys[base+k]);
    return w;
  endfunction

  // Model: output run = every key of both input runs, sorted, P per word, then a zero word.
  task automatic add_run_keys(input int unsigned ka[$], input int unsigned kb[$]);
    int unsigned all[$];
    for (int i = 0; i < ka.size(); i += PP) a_q.push_back(pack(ka, i));
    a_q.push_back('0);
    for (int i = 0; i < kb.size(); i += PP) b_q.push_back(pack(kb, i));
    b_q.push_back('0);
    all = {ka, kb};
    all.sort();
    for (int i = 0; i < all.size(); i += PP) exp_q.push_back(pack(all, i));
    exp_q.push_back('0);
  endtask

  task automatic add_random_run(input int n1, input int n2);
    int unsigned ka[$];
    int unsigned kb[$];
    for (int i = 0; i < n1 * PP; i++) ka.push_back($urandom_range(255, 1));
    for (int i = 0; i < n2 * PP; i++) kb.push_back($urandom_range(255, 1));
    ka.sort();
    kb.sort();
    add_run_keys(ka, kb);
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
  endtask

  task automatic run_traffic(input int vprob, input int rprob, input int stall_at,
                             input int stop_after, input int occ_cyc, input int occ_a,
                             input int occ_b, input int max_cyc);
    int cyc = 0;
    int outs = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_w;
    while (!done && cyc < max_cyc) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == occ_cyc) begin
        check_eq("occ_a", 64'(dut.u_fifo_a.count_q), 64'(occ_a));
        check_eq("occ_b", 64'(dut.u_fifo_b.count_q), 64'(occ_b));
      end
      i_a_valid = (a_q.size() != 0) && ($urandom_range(99) < vprob);
      i_a_data  = (a_q.size() != 0) ? a_q[0] : '0;
      i_b_valid = (b_q.size() != 0) && ($urandom_range(99) < vprob);
      i_b_data  = (b_q.size() != 0) ? b_q[0] : '0;
      i_ready   = ($urandom_range(99) < rprob) &&
                  !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 5);
      #1;
      if (prev_stall) begin
        check_eq("hold_valid", 64'(o_valid), 64'd1);
        check_eq("hold_data", 64'(o_data), 64'(prev_data));
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (i_a_valid && o_a_ready) void'(a_q.pop_front());
      if (i_b_valid && o_b_ready) void'(b_q.pop_front());
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'(o_valid), 64'd0);
        end else begin
          exp_w = exp_q.pop_front();
          $display("xfer out=%h exp=%h run_done=%b", o_data, exp_w, o_run_done);
          check_eq("out_data", 64'(o_data), 64'(exp_w));
          check_eq("run_done", 64'(o_run_done), 64'(exp_w == '0));
          outs++;
        end
      end else if (o_run_done) begin
        check_eq("run_done_idle", 64'(o_run_done), 64'd0);
      end
      done = (stop_after > 0) ? (outs >= stop_after) : (exp_q.size() == 0);
    end
    if (stop_after > 0) check_eq("stop_reached", 64'(outs), 64'(stop_after));
    else                check_eq("drained", 64'(exp_q.size()), 64'd0);
    @(negedge i_clk);
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  initial begin
    int unsigned ka[$];
    int unsigned kb[$];
    int acc;

    reset_dut();
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_data", 64'(o_data), 64'd0);
    check_eq("rst_run_done", 64'(o_run_done), 64'd0);
    check_eq("rst_a_ready", 64'(o_a_ready), 64'd1);
    check_eq("rst_b_ready", 64'(o_b_ready), 64'd1);
    check_eq("rst_state", 64'(dut.state_q), 64'(FILL));

    // Basic interleave.
    ka = {1, 3, 5, 7};
    kb = {2, 4, 6, 8};
    add_run_keys(ka, kb);
    run_traffic(100, 100, 0, 0, 0, 0, 0, 200);

    // Empty run followed by a normal run.
    ka.delete();
    kb.delete();
    add_run_keys(ka, kb);
    add_random_run(2, 3);
    run_traffic(100, 100, 0, 0, 0, 0, 0, 300);

    // One side exhausts first.
    ka = {1, 2, 3, 4};
    kb = {5, 6, 7, 8, 9, 10, 11, 12};
    add_run_keys(ka, kb);
    run_traffic(100, 100, 0, 0, 0, 0, 0, 200);

    // Five cycles of downstream backpressure mid-run.
    add_random_run(4, 3);
    run_traffic(100, 100, 4, 0, 0, 0, 0, 400);

    // FIFO A fills while B stays empty.
    reset_dut();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      i_a_valid = 1'b1;
      i_a_data  = {PP{KW'(c + 1)}};
      i_b_valid = 1'b0;
      i_ready   = 1'b1;
      #1;
      if (o_a_ready) acc++;
    end
    check_eq("a_accepted", 64'(acc), 64'(FD));
    check_eq("a_ready_full", 64'(o_a_ready), 64'd0);
    check_eq("full_no_out", 64'(o_valid), 64'd0);
    reset_dut();

    // Ties: A must be taken first, leaving A=[term], B=[word, term] after two edges.
    ka = {3, 3, 3, 3};
    kb = {3, 3, 3, 3};
    add_run_keys(ka, kb);
    run_traffic(100, 100, 0, 0, 3, 1, 2, 200);

    // Reset after the first output word discards the run.
    add_random_run(3, 3);
    run_traffic(100, 100, 0, 1, 0, 0, 0, 200);
    reset_dut();
    check_eq("mid_rst_valid", 64'(o_valid), 64'd0);
    check_eq("mid_rst_occ_a", 64'(dut.u_fifo_a.count_q), 64'd0);
    check_eq("mid_rst_occ_b", 64'(dut.u_fifo_b.count_q), 64'd0);
    check_eq("mid_rst_state", 64'(dut.state_q), 64'(FILL));
    check_eq("mid_rst_a_ready", 64'(o_a_ready), 64'd1);
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    ka = {10, 20, 30, 40, 50, 60, 70, 80};
    kb = {15, 25, 35, 45};
    add_run_keys(ka, kb);
    run_traffic(100, 100, 0, 0, 0, 0, 0, 200);

    // Random back-to-back runs with random valid and ready.
    for (int r = 0; r < 30; r++) add_random_run($urandom_range(4, 0), $urandom_range(4, 0));
    run_traffic(70, 60, 0, 0, 0, 0, 0, 20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
